su_regfile_nr1w: RTL
====================

SU_REGFILE_NR1W -- requirements
Module: su_regfile_nr1w

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data bits per entry.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning number of entries (2..2**AW).
REQ-003 The block SHALL have parameter AW, default 5, meaning address bits.
REQ-004 The block SHALL have parameter NRD, default 2, meaning number of read ports (1..4).
REQ-005 The block SHALL have parameter R0_ZERO, default 1; when 1, entry 0 reads as zero and ignores writes.
REQ-006 The block SHALL have one clock and an asynchronous, active-low reset, as the next two ports.
REQ-007 clk  input  1  the single clock; all state changes on its rising edge.
REQ-008 reset_l  input  1  asynchronous, active-low reset.
REQ-009 wr_en  input  1  write request this cycle.
REQ-010 wr_inval  input  1  qualifies wr_en: 1 = soft write (invalidate entry), 0 = hard write (store wr_data).
REQ-011 wr_addr  input  AW  binary write address.
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 rd_addr  input  NRD*AW  binary read addresses; port i is bits [i*AW +: AW].
REQ-014 rd_data  output  NRD*WIDTH  registered read data, packed the same way as rd_addr.
REQ-015 rd_valid  output  NRD  per-port flag: the data on that port is valid.
REQ-016 rd_err  output  NRD  per-port flag: the read address was >= DEPTH.
REQ-017 wr_err  output  1  one-cycle pulse when a write is rejected.
REQ-018 err_cnt  output  8  saturating count of rejected writes plus read-port errors.
REQ-019 init_busy  output  1  high while the clear sequencer runs.

Function
REQ-020 The controller SHALL have two states, INIT and RUN; reset forces INIT with clear pointer = 0.
REQ-021 In INIT, each cycle SHALL write entry[ptr] = 0 with valid = 1 and increment ptr.
REQ-022 The controller SHALL leave INIT for RUN on the edge that clears entry DEPTH-1, after exactly DEPTH cycles.
REQ-023 init_busy SHALL equal (state == INIT).
REQ-024 In INIT, all writes SHALL be dropped with a wr_err pulse, and all read ports SHALL return rd_data = 0, rd_valid = 0 and rd_err = 0.
REQ-025 In RUN, a hard write SHALL store wr_data with valid = 1 at the clock edge.
REQ-026 In RUN, a soft write SHALL set valid = 0; the stored data is don't-care but SHALL never appear on rd_data.
REQ-027 A write with wr_addr >= DEPTH SHALL be dropped, cause a wr_err pulse on the next cycle, and leave the array unchanged.
REQ-028 A write to entry 0 with R0_ZERO = 1 SHALL be silently ignored, with no wr_err.
REQ-029 Read latency SHALL be one cycle: rd_data, rd_valid and rd_err for the address presented in cycle n appear after edge n+1.
REQ-030 Reads SHALL be write-first: if cycle n has an accepted write to the same address as a read, the read returns the new contents.
REQ-031 Write-first results: hard write gives wr_data with valid = 1; soft write gives 0 with valid = 0.
REQ-032 A read of an invalid entry SHALL return rd_data = 0 and rd_valid = 0.
REQ-033 A read with rd_addr >= DEPTH SHALL return rd_data = 0, rd_valid = 0 and rd_err = 1.
REQ-034 A read of entry 0 with R0_ZERO = 1 SHALL return rd_data = 0 and rd_valid = 1.
REQ-035 Read ports SHALL be independent; several ports may read the same address in the same cycle.
REQ-036 err_cnt SHALL increment by (wr_err + number of rd_err bits set) on each edge.
REQ-037 err_cnt SHALL saturate at 255 and SHALL NOT wrap.

Reset
REQ-038 Asserting reset_l low SHALL immediately force rd_data = 0, rd_valid = 0, rd_err = 0, wr_err = 0, err_cnt = 0, init_busy = 1, state INIT and ptr = 0.
REQ-039 Reset asserted mid-INIT or mid-RUN SHALL restart the full DEPTH-cycle clear.
REQ-040 Array contents before the clear completes SHALL be unobservable on rd_data.

Verification
REQ-041 Release reset (defaults) -> init_busy high for exactly 32 cycles; after that, every read returns 0 with rd_valid = 1.
REQ-042 Hard write addr 5 = 0xDEADBEEF while port 0 reads addr 5 in the same cycle -> next cycle port 0 = 0xDEADBEEF with rd_valid = 1.
REQ-043 Soft write addr 7, then read addr 7 -> rd_data = 0 and rd_valid = 0; a later hard write of 0x1234 -> reads 0x1234 with rd_valid = 1.
REQ-044 DEPTH = 24: write addr 30 and port 1 read addr 28 -> wr_err pulses once, rd_err[1] = 1, err_cnt = 2, no array entry changes.
REQ-045 Write 0xFFFFFFFF to addr 0 -> read of addr 0 returns 0, no wr_err; then 300 bad writes -> err_cnt holds at 255.
REQ-046 Assert reset_l at cycle 10 of INIT, and separately during RUN after writes -> 32-cycle clear reruns and all entries read 0 afterwards.

Source files
------------

// File: rtl/su_regfile_nr1w.sv
// Multi-read, single-write register file with per-entry valid bits, a power-up
// clear sequencer, write-first read bypass and a saturating error counter.
module su_regfile_nr1w #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 32,
  parameter int AW      = 5,
  parameter int NRD     = 2,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_l,
  input  logic                 wr_en,
  input  logic                 wr_inval,
  input  logic [AW-1:0]        wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*WIDTH-1:0] rd_data,
  output logic [NRD-1:0]       rd_valid,
  output logic [NRD-1:0]       rd_err,
  output logic                 wr_err,
  output logic [7:0]           err_cnt,
  output logic                 init_busy
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        ptr_q, ptr_d;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0]     vld_q;

  logic [NRD*WIDTH-1:0] rd_data_q, rd_data_d;
  logic [NRD-1:0]       rd_valid_q, rd_valid_d;
  logic [NRD-1:0]       rd_err_q, rd_err_d;
  logic                 wr_err_q, wr_err_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 wr_hit;
  logic [AW-1:0]        ra;
  logic [9:0]           err_sum;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_C;
  endfunction

  function automatic logic [7:0] sat8(input logic [9:0] v);
    return (v > 10'd255) ? 8'hFF : v[7:0];
  endfunction

  // Writes land only in RUN, in range, and never on a hard-wired zero entry
  assign wr_hit   = wr_en && (state_q == ST_RUN) && in_range(wr_addr) &&
                    !(R0_ZERO && (wr_addr == '0));
  assign wr_err_d = wr_en && ((state_q == ST_INIT) || !in_range(wr_addr));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == ST_INIT) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == LAST_C) begin
        state_d = ST_RUN;
        ptr_d   = '0;
      end
    end
  end

  // Read path: error, zero entry, write-first bypass, then stored contents
  always_comb begin
    rd_data_d  = '0;
    rd_valid_d = '0;
    rd_err_d   = '0;
    ra         = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = rd_addr[i*AW +: AW];
      if (state_q == ST_RUN) begin
        if (!in_range(ra)) begin
          rd_err_d[i] = 1'b1;
        end else if (R0_ZERO && (ra == '0)) begin
          rd_valid_d[i] = 1'b1;
        end else if (wr_hit && (wr_addr == ra)) begin
          rd_valid_d[i] = !wr_inval;
          if (!wr_inval) rd_data_d[i*WIDTH +: WIDTH] = wr_data;
        end else if (vld_q[ra]) begin
          rd_valid_d[i] = 1'b1;
          rd_data_d[i*WIDTH +: WIDTH] = mem_q[ra];
        end
      end
    end
  end

  always_comb begin
    err_sum = {2'b00, err_cnt_q} + {9'd0, wr_err_q};
    for (int i = 0; i < NRD; i++) begin
      err_sum = err_sum + {9'd0, rd_err_q[i]};
    end
    err_cnt_d = sat8(err_sum);
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= '0;
      rd_err_q   <= '0;
      wr_err_q   <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  // Storage needs no reset: the clear sequencer rewrites every entry first
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[ptr_q] <= '0;
      vld_q[ptr_q] <= 1'b1;
    end else if (wr_hit) begin
      if (!wr_inval) mem_q[wr_addr] <= wr_data;
      vld_q[wr_addr] <= !wr_inval;
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_err    = rd_err_q;
  assign wr_err    = wr_err_q;
  assign err_cnt   = err_cnt_q;
  assign init_busy = (state_q == ST_INIT);

endmodule
